// File: rtl/serial_subtractor_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Gate-level 1-bit full subtractor: d = a ^ b ^ bin, bout = ~a&b | ~(a^b)&bin.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic w_axb, w_na, w_nxab, w_t1, w_t2;

    xor g_x0 (w_axb, i_a, i_b);
    xor g_x1 (o_d, w_axb, i_bin);
    not g_n0 (w_na, i_a);
    not g_n1 (w_nxab, w_axb);
    and g_a0 (w_t1, w_na, i_b);
    and g_a1 (w_t2, w_nxab, i_bin);
    or  g_o0 (o_bout, w_t1, w_t2);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa, r_sb, r_res, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_bf, r_sign_a, r_sign_b;
    logic             r_busy, r_done, r_borrow, r_ovf;
    logic             w_d, w_bnext;
    logic [WIDTH-1:0] w_res_next;

    full_subtractor u_fs (
        .i_a    (r_sa[0]),
        .i_b    (r_sb[0]),
        .i_bin  (r_bf),
        .o_d    (w_d),
        .o_bout (w_bnext)
    );

    // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at LSB.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_bf     <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_res    <= '0;
                        r_bf     <= 1'b0;
                        r_cnt    <= '0;
                        r_sign_a <= a[WIDTH-1];
                        r_sign_b <= b[WIDTH-1];
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_res <= w_res_next;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_bf  <= w_bnext;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_diff   <= w_res_next;
                        r_borrow <= w_bnext;
                        r_ovf    <= (r_sign_a ^ r_sign_b) & (w_d ^ r_sign_a);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Random + directed bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, borrow_out, overflow;
    logic [W-1:0] diff;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sval(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    function automatic bit sovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = sval(x) - sval(y);
        return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    endfunction

    // Model: a countdown of remaining busy cycles plus the pending arithmetic result.
    int           m_cnt = 0;
    bit           m_done = 0, m_bor = 0, m_ovf = 0, p_bor = 0, p_ovf = 0;
    logic [W-1:0] m_diff = '0, p_diff = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 0;
            m_diff <= '0;
            m_bor  <= 0;
            m_ovf  <= 0;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_cnt  <= 0;
            m_done <= 1;
            m_diff <= p_diff;
            m_bor  <= p_bor;
            m_ovf  <= p_ovf;
        end else begin
            m_done <= 0;
            if (start) begin
                m_cnt  <= W;
                p_diff <= W'((int'(a) - int'(b)) & ((1 << W) - 1));
                p_bor  <= (a < b);
                p_ovf  <= sovf(a, b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            chk("cycle", {20'd0, busy, done, diff, borrow_out, overflow},
                {20'd0, (m_cnt != 0), m_done, m_diff, m_bor, m_ovf});
    end

    task automatic wait_done(output int busy_cycles);
        bit seen;
        seen = 0;
        busy_cycles = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (busy) busy_cycles++;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic [W-1:0] ed, input bit eb, input bit eo);
        int bc;
        @(posedge clk); #1;
        start = 1; a = xa; b = xb;
        @(posedge clk); #1;
        start = 0;
        wait_done(bc);
        chk("busy_len", bc, W);
        chk("diff", diff, ed);
        chk("borrow", borrow_out, eb);
        chk("ovf", overflow, eo);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
    endtask

    initial begin
        int bc, ndone;
        #1 rst = 1;
        #1;
        chk("rst_out", {busy, done, diff, borrow_out, overflow}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;

        op(8'd100, 8'd37,  8'd63,  0, 0);
        op(8'd37,  8'd100, 8'hC1,  1, 0);
        op(8'h80,  8'h01,  8'h7F,  0, 1);
        op(8'hFF,  8'hFF,  8'h00,  0, 0);
        op(8'h7F,  8'hFF,  8'h80,  1, 1);

        // Start during RUN must be ignored.
        @(posedge clk); #1;
        start = 1; a = 8'd5; b = 8'd3;
        @(posedge clk); #1;
        start = 0;
        repeat (2) @(posedge clk);
        #1 start = 1; a = 8'd200; b = 8'd1;
        @(posedge clk); #1;
        start = 0;
        wait_done(bc);
        chk("ign_diff", diff, 8'd2);
        chk("ign_borrow", borrow_out, 1'b0);

        // Reset mid-run.
        @(posedge clk); #1;
        start = 1; a = 8'd50; b = 8'd20;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("abort_out", {busy, done, diff, borrow_out, overflow}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        op(8'd9, 8'd9, 8'd0, 0, 0);

        // Continuous start: one result every W+1 cycles.
        @(posedge clk); #1;
        start = 1; a = 8'd10; b = 8'd4;
        ndone = 0;
        for (int i = 0; i < 3 * (W + 1) + 3; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("b2b_diff", diff, 8'd6);
            end
        end
        chk("b2b_count", ndone, 3);
        @(posedge clk); #1;
        start = 0;
        wait_done(bc);
        @(negedge clk);

        // Randomized traffic with corner operands mixed in.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: a = 8'h00;
                1: a = 8'h80;
                2: a = 8'h7F;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: b = 8'hFF;
                1: b = 8'h80;
                2: b = 8'h01;
                default: b = W'($urandom);
            endcase
        end
        @(posedge clk); #1;
        start = 0;
        repeat (W + 3) @(posedge clk);
        @(negedge clk);
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes diff = a - b, one bit per clock, LSB first.
- Uses a single full-subtractor bit cell and a registered borrow, the inverse operation of the team's full-adder cell.
- Sits in the ALU datapath as an area-minimal subtract unit.
- Controlled by a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled at a rising edge of clk only when the block is not busy.
- a  input  WIDTH  minuend; sampled together with start.
- b  input  WIDTH  subtrahend; sampled together with start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse; result is valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH; held until the next accepted start.
- borrow_out  output  1  unsigned borrow (1 when a < b unsigned); held with diff.
- overflow  output  1  signed overflow of a - b; held with diff.

Behaviour:
- Reset: the async assert of rst forces the following, independent of clk:
  - state = IDLE;
  - busy = 0, done = 0, diff = 0, borrow_out = 0, overflow = 0;
  - internal shift registers, borrow flop and bit counter = 0.
- States:
  - IDLE: busy = 0, done = 0.
  - RUN: busy = 1, done = 0.
  - DONE: busy = 0, done = 1 for exactly one cycle.
- IDLE or DONE, start = 1 at edge k:
  - latch a and b into shift registers sa and sb;
  - borrow flop bf = 0, counter = 0;
  - record sign bits a[WIDTH-1] and b[WIDTH-1];
  - go to RUN.
- IDLE, start = 0: stay in IDLE.
- DONE, start = 0: go to IDLE. diff, borrow_out and overflow hold their values.
- RUN, on every edge:
  - d = sa[0] ^ sb[0] ^ bf
  - bnext = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bf)
  - shift d into the result register from the MSB end; shift sa and sb right by 1; bf <= bnext; counter += 1.
- RUN, on the edge where counter == WIDTH-1 (WIDTH edges in RUN in total):
  - go to DONE;
  - diff gets the fully shifted result;
  - borrow_out = final bnext;
  - overflow = (sign_a != sign_b) & (diff[WIDTH-1] != sign_a).
- Latency: start accepted at edge k; done is high in the cycle following edge k+WIDTH (WIDTH+1 edges from acceptance to done).
- start while busy = 1 is ignored; a and b are not re-sampled and the operation is not disturbed.
- Back-to-back: start = 1 during the DONE cycle is accepted. done drops and busy rises at the next edge, so the throughput is one result per WIDTH+1 cycles.
- diff, borrow_out and overflow change only at the RUN -> DONE edge or at reset. During RUN they show the previous result.
- rst asserted mid-RUN aborts the operation. All outputs go to 0 immediately, no done pulse is produced, and the block restarts in IDLE.
- Counter width is clog2(WIDTH). There is no wrap-around hazard because the counter is reset on every accepted start.

Decomposition:
- Shared package / include holds:
  - state encodings: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2 (2'd3 is illegal and recovers to IDLE);
  - the default WIDTH constant.
- One sub-module: full_subtractor, a combinational 1-bit cell (a, b, bin -> d, bout) that mirrors the gate-level full-adder cell (xor/and/or primitives with inverted minuend terms).
- The top level holds the FSM, the shift registers, the borrow flop and the counter.

Test Plan:
- a = 100, b = 37, start pulse -> busy for 8 cycles, done one cycle later with diff = 63, borrow_out = 0, overflow = 0; done is high for exactly 1 cycle.
- a = 37, b = 100 -> diff = 8'hC1, borrow_out = 1, overflow = 0.
- a = 8'h80, b = 8'h01 -> diff = 8'h7F, borrow_out = 0, overflow = 1.
- Start a = 5, b = 3; at cycle 3 of RUN pulse start with a = 200, b = 1 -> the second request is ignored; result diff = 2, borrow_out = 0.
- Start a = 50, b = 20; assert rst at RUN cycle 4 -> all outputs become 0 asynchronously, there is no done pulse, and state = IDLE. After rst is released, a new start with a = 9, b = 9 gives diff = 0, borrow_out = 0.
- start held high continuously with a = 10, b = 4 -> done pulses every 9 cycles with diff = 6 each time; busy = 0 only during the DONE cycles.
